// File: rtl/qam_pkg.sv
// Shared definitions for the QAM symbol controller: mode codes, FSM states, bits-per-symbol helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package qam_pkg;

    // Modulation order as driven on the mode port. The reserved code is mapped as BPSK.
    typedef enum logic [1:0] {
        MODE_BPSK  = 2'd0,
        MODE_QPSK  = 2'd1,
        MODE_16QAM = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_e;

    // Widest symbol index (16QAM) and the bit counter wide enough to reach it.
    localparam int SYM_W  = 4;
    localparam int BCNT_W = 3;

    // Bits carried per symbol for a given mode.
    function automatic logic [BCNT_W-1:0] bits_per_mode(input mode_e m);
        case (m)
            MODE_QPSK:  bits_per_mode = 3'd2;
            MODE_16QAM: bits_per_mode = 3'd4;
            default:    bits_per_mode = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/qam_bit_packer.sv
// Serial-to-symbol packer: shifts accepted bits MSB-first into a right-justified symbol index.
// Latency: sym_done is combinational with the accept of the last bit; shreg valid the next cycle.
// Backpressure: none internally; the caller only asserts bit_acc when it can take a bit.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   bit_acc       - a bit is accepted this cycle
//   bit_in        - the bit being accepted
//   mode          - current modulation mode (sampled on the first bit of a symbol)
//   shreg         - packed symbol index, unused upper bits zero
//   active_mode   - mode latched for the symbol in progress
//   sym_done      - this accept completes the symbol
module qam_bit_packer
    import qam_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_acc,
    input  logic             bit_in,
    input  mode_e            mode,
    output logic [SYM_W-1:0] shreg,
    output mode_e            active_mode,
    output logic             sym_done
);

    logic [BCNT_W-1:0] bit_cnt;
    logic              first_bit;
    mode_e             eff_mode;

    // On the first bit the latched mode is not yet updated, so use the live one.
    assign first_bit = (bit_cnt == '0);
    assign eff_mode  = first_bit ? mode : active_mode;
    assign sym_done  = bit_acc && ((bit_cnt + 3'd1) == bits_per_mode(eff_mode));

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            active_mode <= MODE_BPSK;
        end else if (bit_acc) begin
            if (first_bit) begin
                active_mode <= mode;
                // Start from a clean register so short symbols are right-justified with zero MSBs.
                shreg       <= {{(SYM_W-1){1'b0}}, bit_in};
            end else begin
                shreg       <= {shreg[SYM_W-2:0], bit_in};
            end
            bit_cnt <= sym_done ? '0 : bit_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/qam_sym_ctrl.sv
// QAM symbol controller: packs serial bits, strobes one mapper, captures and hands off its sample.
// Latency: last bit accepted at t -> sel_x at t+1 -> sym_valid at t+3.
// Backpressure: holds sym_out until sym_ready; bit_ready low from ISSUE through HOLD (no buffering).
//
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   mode                              - 0 BPSK, 1 QPSK, 2 16QAM, 3 treated as BPSK
//   bit_in, bit_valid, bit_ready      - serial payload handshake
//   sel_2, sel_4, sel_16              - one-cycle select strobes to the mappers
//   sym_bits                          - symbol index to mappers, right-justified
//   map_out_2, map_out_4, map_out_16  - registered mapper outputs
//   sym_out, sym_valid, sym_ready     - captured sample handshake
//   sym_count                         - symbols handed off, wraps
module qam_sym_ctrl
    import qam_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              bit_ready,
    output logic              sel_2,
    output logic              sel_4,
    output logic              sel_16,
    output logic [SYM_W-1:0]  sym_bits,
    input  logic [DATA_W-1:0] map_out_2,
    input  logic [DATA_W-1:0] map_out_4,
    input  logic [DATA_W-1:0] map_out_16,
    output logic [DATA_W-1:0] sym_out,
    output logic              sym_valid,
    input  logic              sym_ready,
    output logic [CNT_W-1:0]  sym_count
);

    state_e            state_q;
    state_e            state_d;
    logic              bit_acc;
    logic              sym_done;
    logic [SYM_W-1:0]  shreg;
    mode_e             active_mode;
    logic [DATA_W-1:0] map_sel;

    assign bit_acc = bit_valid && bit_ready;

    qam_bit_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .bit_acc     (bit_acc),
        .bit_in      (bit_in),
        .mode        (mode_e'(mode)),
        .shreg       (shreg),
        .active_mode (active_mode),
        .sym_done    (sym_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_COLLECT: if (sym_done) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_HOLD;
            ST_HOLD:    if (sym_ready) state_d = ST_COLLECT;
            default:    state_d = ST_COLLECT;
        endcase
    end

    // Outputs. Everything is qualified with !rst so a reset landing in ISSUE or HOLD
    // produces no strobe or valid during the reset cycle itself.
    always_comb begin
        bit_ready = 1'b0;
        sel_2     = 1'b0;
        sel_4     = 1'b0;
        sel_16    = 1'b0;
        sym_valid = 1'b0;
        sym_bits  = '0;
        if (!rst) begin
            bit_ready = (state_q == ST_COLLECT);
            sym_valid = (state_q == ST_HOLD);
            // Partial symbols are not shown to the mappers while still collecting.
            if (state_q != ST_COLLECT) begin
                sym_bits = shreg;
            end
            if (state_q == ST_ISSUE) begin
                case (active_mode)
                    MODE_QPSK:  sel_4  = 1'b1;
                    MODE_16QAM: sel_16 = 1'b1;
                    default:    sel_2  = 1'b1;
                endcase
            end
        end
    end

    // Pick the mapper that was strobed for this symbol.
    always_comb begin
        case (active_mode)
            MODE_QPSK:  map_sel = map_out_4;
            MODE_16QAM: map_sel = map_out_16;
            default:    map_sel = map_out_2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sym_out   <= '0;
            sym_count <= '0;
        end else begin
            if (state_q == ST_CAPTURE) begin
                sym_out <= map_sel;
            end
            if ((state_q == ST_HOLD) && sym_ready) begin
                sym_count <= sym_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/qam_sym_ctrl.md
QAM_SYM_CTRL -- requirements
Module: qam_sym_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning mapper sample width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning symbol-counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port mode, input, 2, modulation order: 0=BPSK (k=1), 1=QPSK (k=2), 2=16QAM (k=4), 3=reserved, treated as BPSK.
REQ-006 SHALL have port bit_in, input, 1, serial payload bit.
REQ-007 SHALL have port bit_valid, input, 1, bit_in valid.
REQ-008 SHALL have port bit_ready, output, 1, controller accepts bit this cycle.
REQ-009 SHALL have port sel_2, sel_4 and sel_16, each output, 1, one-cycle select strobe to the 2-, 4- and 16-point mapper respectively.
REQ-010 SHALL have port sym_bits, output, 4, symbol index to mappers, right-justified.
REQ-011 SHALL have port map_out_2, map_out_4 and map_out_16, each input, DATA_W, registered mapper outputs.
REQ-012 SHALL have port sym_out, output, DATA_W, captured constellation sample.
REQ-013 SHALL have port sym_valid, output, 1, sym_out valid.
REQ-014 SHALL have port sym_ready, input, 1, downstream accepts sym_out.
REQ-015 SHALL have port sym_count, output, CNT_W, count of symbols handed off.

Function
REQ-016 SHALL implement FSM states COLLECT, ISSUE, CAPTURE, HOLD.
REQ-017 COLLECT: bit_ready=1; a bit is accepted when bit_valid && bit_ready; all other outputs idle.
REQ-018 SHALL latch mode into active_mode when the first bit of a symbol is accepted (bit counter = 0); changes to mode at any other time SHALL NOT affect the symbol in progress.
REQ-019 Bits SHALL shift in MSB-first: the first accepted bit becomes sym_bits[k-1]; unused upper sym_bits SHALL be 0.
REQ-020 On acceptance of bit k of a symbol, the FSM SHALL go COLLECT->ISSUE and the bit counter SHALL clear.
REQ-021 ISSUE: exactly one of sel_2/sel_4/sel_16, per active_mode, SHALL be 1 for exactly one cycle; sym_bits SHALL be stable; next state CAPTURE; bit_ready=0.
REQ-022 CAPTURE: sym_out SHALL load map_out_x of the active mapper; sym_valid SHALL be 1 from the next cycle; next state HOLD.
REQ-023 Latency: last bit accepted in cycle t -> sel_x high in t+1 -> sym_valid high in t+3.
REQ-024 HOLD: sym_valid=1 and sym_out SHALL stay constant until sym_valid && sym_ready; on that cycle sym_count SHALL increment and the FSM SHALL return to COLLECT, with sym_valid low next cycle.
REQ-025 bit_ready SHALL be 0 in ISSUE, CAPTURE and HOLD: no bit buffering. Peak BPSK throughput is one symbol per 4 cycles.
REQ-026 sym_count SHALL wrap from 2^CNT_W-1 to 0 without saturation.
REQ-027 All sel_* SHALL be 0 outside ISSUE; never more than one sel_* high.

Reset
REQ-028 While rst=1: state=COLLECT, bit counter=0, shift register=0, active_mode=0, sym_out=0, sym_valid=0, sel_*=0, sym_bits=0, sym_count=0. bit_ready SHALL be 0 during reset and 1 the cycle after.
REQ-029 Reset asserted in any state, including mid-symbol or in HOLD, SHALL discard the partial or pending symbol with no sel_* strobe and no sym_count increment.

Structure
REQ-030 Mode encodings, the bits-per-mode function and FSM state encodings SHALL reside in the shared package qam_pkg.
REQ-031 The bit-to-symbol shift register plus counter SHALL be a sub-module qam_bit_packer; the FSM, mux and counter stay in qam_sym_ctrl.

Verification
REQ-032 BPSK, bit 1 at t -> sel_2=1 at t+1 with sym_bits=0001; bench mapper returns 0x00000FFF -> sym_out=0x00000FFF with sym_valid at t+3.
REQ-033 QPSK, bits 1,0 -> sel_4 single pulse, sym_bits=0010; 16QAM bits 1,0,1,1 -> sel_16 pulse, sym_bits=1011; sel_2 stays 0.
REQ-034 sym_ready held 0 for 5 cycles in HOLD -> sym_out and sym_valid stable, bit_ready=0, sym_count unchanged; on release sym_count +1.
REQ-035 mode switched 2->0 after first of 4 bits -> symbol completes as 16QAM; the next symbol is BPSK.
REQ-036 rst pulsed for 1 cycle in ISSUE -> no sym_valid, sym_count=0, bit_ready=1 the next cycle; preload sym_count=0xFFFF -> one handshake wraps it to 0x0000.
